ts_pulser: RTL and testbench

Time-slot sequencer and pulser for one probe channel. Steps a 2-bit slot index through four time slots. For each slot it samples that slot's parameter set from the per-slot parameter table, driven combinationally from o_slot. It generates the hit/gnd excitation burst on four lanes, then a hush (blanking) interval, then a one-cycle ADC start strobe. It sits between the parameter table and the pulser drivers / ADC capture.

---
 rtl/ts_pulser.sv | 253 +++++++++++++++++++++++++
 tb/tb_ts_pulser.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_pulser.sv
// ts_pulser: time-slot sequencer and pulser for one probe channel.
// Steps o_slot through four slots; each slot fires a hit/gnd burst on the
// masked lanes, then a hush (blanking) interval, then a one-cycle ADC start.
// Optional feature macro: DEADTIME_EN inserts DEAD_TICKS idle cycles at every
// HIT->GND and GND->HIT transition inside a burst.
// Handshake: none. Parameters are sampled only on the o_slot_start cycle,
// when the table is already addressed by the new o_slot value.
// MIN_TS must be at least 2 so offset 0 is never the last cycle of a slot.
module ts_pulser #(
    parameter int unsigned DEAD_TICKS = 2,
    parameter int unsigned MIN_TS     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [15:0] i_ts_time,
    input  logic [3:0]  i_pulse_mask,
    input  logic [7:0]  i_pulse_hit,
    input  logic [7:0]  i_pulse_gnd,
    input  logic [3:0]  i_pulse_count,
    input  logic [15:0] i_pulse_hush,
    output logic [1:0]  o_slot,
    output logic        o_slot_start,
    output logic [3:0]  o_hit,
    output logic [3:0]  o_gnd,
    output logic        o_hush,
    output logic        o_adc_start,
    output logic        o_busy
);

    typedef enum logic [2:0] {IDLE, HIT, GND, HUSH, ADC, WAIT} state_t;

    state_t      state, n_state;
    logic [7:0]  ph_cnt, n_ph;        // cycles left in current hit/gnd phase after this one
    logic [15:0] hush_cnt, n_hcnt;    // cycles left in hush after this one
    logic [3:0]  pair_cnt, n_pair;    // pairs left, including the current one
    logic [15:0] ts_cnt, n_ts;        // offset within the slot
    logic [15:0] ts_last;             // last offset of the current slot
    logic [1:0]  n_slot;
    logic        n_start, n_hush, n_adc, n_busy;
    logic [3:0]  n_hit, n_gnd;

    logic [3:0]  lat_mask, lat_count;
    logic [7:0]  lat_hit, lat_gnd;
    logic [15:0] lat_hush;

    // Effective parameters: live table values on the start cycle, latched ones after
    logic [3:0]  p_mask, p_count;
    logic [7:0]  p_hit, p_gnd;
    logic [15:0] p_hush, ts_eff;

    assign p_mask  = o_slot_start ? i_pulse_mask  : lat_mask;
    assign p_count = o_slot_start ? i_pulse_count : lat_count;
    assign p_hit   = o_slot_start ? i_pulse_hit   : lat_hit;
    assign p_gnd   = o_slot_start ? i_pulse_gnd   : lat_gnd;
    assign p_hush  = o_slot_start ? i_pulse_hush  : lat_hush;
    assign ts_eff  = (i_ts_time < 16'(MIN_TS)) ? 16'(MIN_TS) : i_ts_time;

    // Entry into the blanking interval (a zero hush goes straight to ADC)
    state_t      hz_state;
    logic        hz_hush, hz_adc;
    assign hz_state = (p_hush != 16'd0) ? HUSH : ADC;
    assign hz_hush  = (p_hush != 16'd0);
    assign hz_adc   = (p_hush == 16'd0);

`ifdef DEADTIME_EN
    localparam logic [7:0] DEAD8 = 8'(DEAD_TICKS);
    logic [7:0] dead_cnt, n_dead;     // dead cycles left before the phase drives
`else
    logic unused_dead_ticks;
    assign unused_dead_ticks = (DEAD_TICKS != 0);
`endif

    // Next-state and next-output decode for the slot timer and burst FSM
    always_comb begin
        n_state = state;
        n_ph    = ph_cnt;
        n_hcnt  = hush_cnt;
        n_pair  = pair_cnt;
        n_ts    = ts_cnt + 16'd1;
        n_slot  = o_slot;
        n_start = 1'b0;
        n_hit   = 4'd0;
        n_gnd   = 4'd0;
        n_hush  = 1'b0;
        n_adc   = 1'b0;
`ifdef DEADTIME_EN
        n_dead  = dead_cnt;
`endif
        if (!i_enable) begin
            n_state = IDLE;
            n_ts    = 16'd0;
            n_slot  = 2'd0;
        end else if (state == IDLE) begin
            n_state = WAIT;
            n_ts    = 16'd0;
            n_slot  = 2'd0;
            n_start = 1'b1;
        end else if (o_slot_start) begin
            // Offset 0: decide how the burst begins, skipping empty phases
            n_pair = p_count;
            if (p_count == 4'd0 || p_mask == 4'd0 || (p_hit == 8'd0 && p_gnd == 8'd0)) begin
                n_state = hz_state;
                n_hcnt  = p_hush - 16'd1;
                n_hush  = hz_hush;
                n_adc   = hz_adc;
            end else if (p_hit != 8'd0) begin
                n_state = HIT;
                n_ph    = p_hit - 8'd1;
                n_hit   = p_mask;
            end else begin
                n_state = GND;
                n_ph    = p_gnd - 8'd1;
                n_gnd   = p_mask;
            end
        end else if (ts_cnt == ts_last) begin
            // Slot ends: any unfinished burst is dropped, outputs go low
            n_state = WAIT;
            n_ts    = 16'd0;
            n_slot  = o_slot + 2'd1;
            n_start = 1'b1;
        end else begin
            case (state)
                HIT: begin
`ifdef DEADTIME_EN
                    if (dead_cnt != 8'd0) begin
                        n_dead = dead_cnt - 8'd1;
                        if (dead_cnt == 8'd1) n_hit = p_mask;
                    end else
`endif
                    if (ph_cnt != 8'd0) begin
                        n_ph  = ph_cnt - 8'd1;
                        n_hit = p_mask;
                    end else if (p_gnd != 8'd0) begin
                        n_state = GND;
                        n_ph    = p_gnd - 8'd1;
`ifdef DEADTIME_EN
                        n_dead  = DEAD8;
                        if (DEAD8 == 8'd0) n_gnd = p_mask;
`else
                        n_gnd   = p_mask;
`endif
                    end else if (pair_cnt > 4'd1) begin
                        n_pair = pair_cnt - 4'd1;
                        n_ph   = p_hit - 8'd1;
                        n_hit  = p_mask;
                    end else begin
                        n_state = hz_state;
                        n_hcnt  = p_hush - 16'd1;
                        n_hush  = hz_hush;
                        n_adc   = hz_adc;
                    end
                end
                GND: begin
`ifdef DEADTIME_EN
                    if (dead_cnt != 8'd0) begin
                        n_dead = dead_cnt - 8'd1;
                        if (dead_cnt == 8'd1) n_gnd = p_mask;
                    end else
`endif
                    if (ph_cnt != 8'd0) begin
                        n_ph  = ph_cnt - 8'd1;
                        n_gnd = p_mask;
                    end else if (pair_cnt > 4'd1) begin
                        n_pair = pair_cnt - 4'd1;
                        if (p_hit != 8'd0) begin
                            n_state = HIT;
                            n_ph    = p_hit - 8'd1;
`ifdef DEADTIME_EN
                            n_dead  = DEAD8;
                            if (DEAD8 == 8'd0) n_hit = p_mask;
`else
                            n_hit   = p_mask;
`endif
                        end else begin
                            n_ph  = p_gnd - 8'd1;
                            n_gnd = p_mask;
                        end
                    end else begin
                        n_state = hz_state;
                        n_hcnt  = p_hush - 16'd1;
                        n_hush  = hz_hush;
                        n_adc   = hz_adc;
                    end
                end
                HUSH: begin
                    if (hush_cnt != 16'd0) begin
                        n_hcnt = hush_cnt - 16'd1;
                        n_hush = 1'b1;
                    end else begin
                        n_state = ADC;
                        n_adc   = 1'b1;
                    end
                end
                ADC:     n_state = WAIT;
                default: n_state = state;
            endcase
        end
        n_busy = (n_state != IDLE) && (n_state != WAIT);
    end

    // State, counters, parameter latch and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            ph_cnt       <= 8'd0;
            hush_cnt     <= 16'd0;
            pair_cnt     <= 4'd0;
            ts_cnt       <= 16'd0;
            ts_last      <= 16'd0;
            lat_mask     <= 4'd0;
            lat_count    <= 4'd0;
            lat_hit      <= 8'd0;
            lat_gnd      <= 8'd0;
            lat_hush     <= 16'd0;
            o_slot       <= 2'd0;
            o_slot_start <= 1'b0;
            o_hit        <= 4'd0;
            o_gnd        <= 4'd0;
            o_hush       <= 1'b0;
            o_adc_start  <= 1'b0;
            o_busy       <= 1'b0;
`ifdef DEADTIME_EN
            dead_cnt     <= 8'd0;
`endif
        end else begin
            state        <= n_state;
            ph_cnt       <= n_ph;
            hush_cnt     <= n_hcnt;
            pair_cnt     <= n_pair;
            ts_cnt       <= n_ts;
            o_slot       <= n_slot;
            o_slot_start <= n_start;
            o_hit        <= n_hit;
            o_gnd        <= n_gnd;
            o_hush       <= n_hush;
            o_adc_start  <= n_adc;
            o_busy       <= n_busy;
`ifdef DEADTIME_EN
            dead_cnt     <= n_dead;
`endif
            if (o_slot_start) begin
                lat_mask  <= i_pulse_mask;
                lat_count <= i_pulse_count;
                lat_hit   <= i_pulse_hit;
                lat_gnd   <= i_pulse_gnd;
                lat_hush  <= i_pulse_hush;
                ts_last   <= ts_eff - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ts_pulser.sv
// tb_ts_pulser: directed bench for ts_pulser. A four-entry parameter table is
// addressed combinationally by o_slot; outputs are sampled on the falling edge.
module tb_ts_pulser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [15:0] i_ts_time;
    logic [3:0]  i_pulse_mask;
    logic [7:0]  i_pulse_hit;
    logic [7:0]  i_pulse_gnd;
    logic [3:0]  i_pulse_count;
    logic [15:0] i_pulse_hush;
    logic [1:0]  o_slot;
    logic        o_slot_start;
    logic [3:0]  o_hit;
    logic [3:0]  o_gnd;
    logic        o_hush;
    logic        o_adc_start;
    logic        o_busy;

    logic [15:0] tbl_ts[4];
    logic [3:0]  tbl_mask[4];
    logic [7:0]  tbl_hit[4];
    logic [7:0]  tbl_gnd[4];
    logic [3:0]  tbl_cnt[4];
    logic [15:0] tbl_hush[4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign i_ts_time     = tbl_ts[o_slot];
    assign i_pulse_mask  = tbl_mask[o_slot];
    assign i_pulse_hit   = tbl_hit[o_slot];
    assign i_pulse_gnd   = tbl_gnd[o_slot];
    assign i_pulse_count = tbl_cnt[o_slot];
    assign i_pulse_hush  = tbl_hush[o_slot];

    ts_pulser #(.DEAD_TICKS(2), .MIN_TS(2)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
        .i_ts_time(i_ts_time), .i_pulse_mask(i_pulse_mask),
        .i_pulse_hit(i_pulse_hit), .i_pulse_gnd(i_pulse_gnd),
        .i_pulse_count(i_pulse_count), .i_pulse_hush(i_pulse_hush),
        .o_slot(o_slot), .o_slot_start(o_slot_start), .o_hit(o_hit),
        .o_gnd(o_gnd), .o_hush(o_hush), .o_adc_start(o_adc_start),
        .o_busy(o_busy)
    );

    // {hit, gnd, hush, adc_start, slot_start, busy}
    function automatic logic [11:0] pack(input logic [3:0] h, input logic [3:0] g,
                                         input logic hu, input logic a,
                                         input logic s, input logic b);
        return {h, g, hu, a, s, b};
    endfunction

    function automatic logic [11:0] obs();
        return {o_hit, o_gnd, o_hush, o_adc_start, o_slot_start, o_busy};
    endfunction

    task automatic set_all(input logic [15:0] ts, input logic [3:0] mask,
                           input logic [7:0] hit, input logic [7:0] gnd,
                           input logic [3:0] cnt, input logic [15:0] hush);
        for (int i = 0; i < 4; i++) begin
            tbl_ts[i] = ts; tbl_mask[i] = mask; tbl_hit[i] = hit;
            tbl_gnd[i] = gnd; tbl_cnt[i] = cnt; tbl_hush[i] = hush;
        end
    endtask

    // Park in IDLE, then enable; returns at the offset-0 sample of slot 0
    task automatic start_run();
        i_enable = 1'b0;
        @(negedge clk);
        i_enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if (obs() !== 12'h000 || o_slot !== 2'd0) begin
            errors++;
            $display("FAIL reset got=%03h slot=%0d exp=000 slot=0", obs(), o_slot);
        end
    endtask

    task automatic test_timing();
        logic [11:0] ev;
        int w;
        set_all(16'd3600, 4'b0001, 8'd40, 8'd40, 4'd4, 16'd1000);
        start_run();
        checks++;
        if (o_slot_start !== 1'b1 || o_slot !== 2'd0) begin
            errors++;
            $display("FAIL timing_start got start=%0b slot=%0d exp start=1 slot=0", o_slot_start, o_slot);
        end
        for (int k = 1; k < 3600; k++) begin
            @(negedge clk);
            w = (k - 1) % 80;
            ev = pack((k <= 320 && w < 40) ? 4'b0001 : 4'b0000,
                      (k <= 320 && w >= 40) ? 4'b0001 : 4'b0000,
                      k >= 321 && k <= 1320, k == 1321, 1'b0, k <= 1321);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL timing off=%0d got=%03h exp=%03h", k, obs(), ev);
            end
        end
        @(negedge clk);
        checks++;
        if (o_slot_start !== 1'b1 || o_slot !== 2'd1 || obs() !== pack(4'd0, 4'd0, 0, 0, 1, 0)) begin
            errors++;
            $display("FAIL timing_next got=%03h slot=%0d exp=002 slot=1", obs(), o_slot);
        end
    endtask

    task automatic test_overrun();
        logic [11:0] ev;
        int w;
        set_all(16'd100, 4'b0001, 8'd40, 8'd40, 4'd4, 16'd1000);
        start_run();
        for (int k = 1; k < 100; k++) begin
            @(negedge clk);
            w = (k - 1) % 80;
            ev = pack(w < 40 ? 4'b0001 : 4'b0000, w >= 40 ? 4'b0001 : 4'b0000, 0, 0, 0, 1);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL overrun off=%0d got=%03h exp=%03h", k, obs(), ev);
            end
        end
        @(negedge clk);
        checks++;
        if (obs() !== pack(4'd0, 4'd0, 0, 0, 1, 0) || o_slot !== 2'd1) begin
            errors++;
            $display("FAIL overrun_cut got=%03h slot=%0d exp=002 slot=1", obs(), o_slot);
        end
        @(negedge clk);
        checks++;
        if (obs() !== pack(4'b0001, 4'd0, 0, 0, 0, 1)) begin
            errors++;
            $display("FAIL overrun_restart got=%03h exp=%03h", obs(), pack(4'b0001, 4'd0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_zero();
        logic [11:0] ev;
        set_all(16'd20, 4'b1010, 8'd0, 8'd3, 4'd2, 16'd2);
        tbl_mask[0] = 4'b0001; tbl_hit[0] = 8'd7; tbl_gnd[0] = 8'd7;
        tbl_cnt[0] = 4'd0; tbl_hush[0] = 16'd5;
        start_run();
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            ev = pack(4'd0, 4'd0, k <= 5, k == 6, 0, k <= 6);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL zero_count off=%0d got=%03h exp=%03h", k, obs(), ev);
            end
        end
        @(negedge clk);
        checks++;
        if (o_slot_start !== 1'b1 || o_slot !== 2'd1) begin
            errors++;
            $display("FAIL zero_next got start=%0b slot=%0d exp start=1 slot=1", o_slot_start, o_slot);
        end
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            ev = pack(4'd0, k <= 6 ? 4'b1010 : 4'b0000, k == 7 || k == 8, k == 9, 0, k <= 9);
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL zero_hit off=%0d got=%03h exp=%03h", k, obs(), ev);
            end
        end
    endtask

    task automatic test_wrap_clamp();
        int lens[4];
        logic [3:0] ev, ov;
        lens = '{2, 3, 2, 5};
        set_all(16'd0, 4'd0, 8'd1, 8'd1, 4'd0, 16'd0);
        tbl_ts[1] = 16'd3; tbl_ts[2] = 16'd1; tbl_ts[3] = 16'd5;
        start_run();
        for (int s = 0; s < 5; s++) begin
            for (int off = 0; off < lens[s % 4]; off++) begin
                if (!(s == 0 && off == 0)) @(negedge clk);
                ev = {2'(s % 4), off == 0, off == 1};
                ov = {o_slot, o_slot_start, o_adc_start};
                checks++;
                if (ov !== ev) begin
                    errors++;
                    $display("FAIL wrap s=%0d off=%0d got=%h exp=%h", s, off, ov, ev);
                end
            end
        end
    endtask

    task automatic test_enable();
        set_all(16'd400, 4'b0110, 8'd10, 8'd10, 4'd4, 16'd100);
        tbl_ts[0] = 16'd30; tbl_mask[0] = 4'd0; tbl_cnt[0] = 4'd0; tbl_hush[0] = 16'd0;
        start_run();
        repeat (30) @(negedge clk);
        checks++;
        if (o_slot_start !== 1'b1 || o_slot !== 2'd1) begin
            errors++;
            $display("FAIL enable_slot1 got start=%0b slot=%0d exp start=1 slot=1", o_slot_start, o_slot);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (o_hit !== 4'b0110 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL enable_hit50 got hit=%b busy=%0b exp hit=0110 busy=1", o_hit, o_busy);
        end
        i_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 12'h000 || o_slot !== 2'd0) begin
                errors++;
                $display("FAIL enable_low k=%0d got=%03h slot=%0d exp=000 slot=0", k, obs(), o_slot);
            end
        end
        i_enable = 1'b1;
        @(negedge clk);
        checks++;
        if (o_slot_start !== 1'b1 || o_slot !== 2'd0) begin
            errors++;
            $display("FAIL enable_rise got start=%0b slot=%0d exp start=1 slot=0", o_slot_start, o_slot);
        end
    endtask

    task automatic test_reset_mid();
        set_all(16'd3600, 4'b0001, 8'd40, 8'd40, 4'd4, 16'd1000);
        start_run();
        repeat (20) @(negedge clk);
        checks++;
        if (o_hit !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_hit got=%b exp=0001", o_hit);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (obs() !== 12'h000 || o_slot !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_zero got=%03h slot=%0d exp=000 slot=0", obs(), o_slot);
        end
        @(negedge clk);
        checks++;
        if (o_slot_start !== 1'b1 || o_slot !== 2'd0 || o_hit !== 4'd0) begin
            errors++;
            $display("FAIL rstmid_restart got start=%0b slot=%0d hit=%b exp start=1 slot=0 hit=0000", o_slot_start, o_slot, o_hit);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ev;
        logic        h, g;
        set_all(16'd40, 4'b1001, 8'd4, 8'd4, 4'd2, 16'd2);
        start_run();
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
`ifdef DEADTIME_EN
            h = (k >= 1 && k <= 4) || (k >= 13 && k <= 16);
            g = (k >= 7 && k <= 10) || (k >= 19 && k <= 22);
            ev = pack(h ? 4'b1001 : 4'd0, g ? 4'b1001 : 4'd0, k == 23 || k == 24, k == 25, 0, k <= 25);
`else
            h = (k >= 1 && k <= 4) || (k >= 9 && k <= 12);
            g = (k >= 5 && k <= 8) || (k >= 13 && k <= 16);
            ev = pack(h ? 4'b1001 : 4'd0, g ? 4'b1001 : 4'd0, k == 17 || k == 18, k == 19, 0, k <= 19);
`endif
            checks++;
            if (obs() !== ev) begin
                errors++;
                $display("FAIL back_to_back off=%0d got=%03h exp=%03h", k, obs(), ev);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        i_enable = 1'b1;
        set_all(16'd10, 4'd0, 8'd0, 8'd0, 4'd0, 16'd0);
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_timing();
        test_overrun();
        test_zero();
        test_wrap_clamp();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
